vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the 160x120 vga_adapter between up to NUM_REQ drawing engines, e.g. fillscreen plus later circle and line drawers.
- Uses round-robin grants. A granted engine owns the port until it drops its request.
- Sits between the drawing engines and vga_adapter in the task top level.
- Registers the muxed x/y/colour/plot, clips off-screen writes and counts them.

Parameters:
- NUM_REQ, 4, number of requesters (2..8). IDW = $clog2(NUM_REQ) is a derived localparam.
- SCREEN_W, 160, pixel columns; plots with x >= SCREEN_W are clipped.
- SCREEN_H, 120, pixel rows; plots with y >= SCREEN_H are clipped.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst_n  in  1  asynchronous active-low reset (KEY[3] at top).
- req  in  NUM_REQ  per-requester port request; held high for the whole drawing burst.
- gnt  out  NUM_REQ  one-hot grant; at most one bit high.
- req_x  in  NUM_REQ*8  packed x; requester i uses bits [8i+7:8i].
- req_y  in  NUM_REQ*7  packed y; requester i uses bits [7i+6:7i].
- req_colour  in  NUM_REQ*3  packed colour.
- req_plot  in  NUM_REQ  per-requester plot strobe.
- vga_x  out  8  to adapter x.
- vga_y  out  7  to adapter y.
- vga_colour  out  3  to adapter colour.
- vga_plot  out  1  to adapter plot.
- owner  out  IDW  index of the current or last grantee.
- busy  out  1  high while in GRANT.
- clip_cnt  out  16  saturating count of clipped plots.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: gnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, owner=0, busy=0, clip_cnt=0, state=IDLE, last_owner=NUM_REQ-1 (so requester 0 wins first).
- FSM states: IDLE, GRANT, HANDOFF.
- IDLE and HANDOFF arbitrate identically:
  - If any req bit is high, choose the first set bit searching from (last_owner+1) mod NUM_REQ upward with wrap.
  - Next edge: gnt[i]=1, owner=i, last_owner=i, state=GRANT.
  - If no req bit is high: IDLE→IDLE and HANDOFF→IDLE.
- Grant latency: req sampled high at edge k gives gnt visible after edge k.
- GRANT:
  - Each edge: vga_x/vga_y/vga_colour <= the owner's slice.
  - vga_plot <= req_plot[owner] AND (x < SCREEN_W) AND (y < SCREEN_H).
  - Pixel latency is 1 cycle from the requester's signals to the adapter.
- GRANT release:
  - If req[owner] is sampled 0, then next edge: gnt=0, vga_plot=0, state=HANDOFF.
  - The owner's plot in its release cycle is discarded.
  - Any hand-over therefore has at least one cycle with no grant and no plot.
- Non-owners: req_plot, x, y and colour from non-owners are ignored at all times. Requests arriving during GRANT wait.
- Outside GRANT: vga_plot=0; vga_x/vga_y/vga_colour hold their last values; busy=0.
- Clipping: an owner plot with x >= SCREEN_W or y >= SCREEN_H gives vga_plot=0. clip_cnt increments and saturates at 16'hFFFF.
- Simultaneous requests: the round-robin pointer decides. A requester that re-raises req in HANDOFF is lowest priority if others are waiting; if it is alone it is re-granted after the single HANDOFF cycle.
- Reset mid-operation: asserting rst_n=0 in any state forces reset values immediately (asynchronously), with no partial pixel output.

Test Plan:
- Reset then idle, req=0 for 10 cycles → gnt=0, vga_plot=0, busy=0, clip_cnt=0.
- req[1]=1 at edge k; requester 1 drives x=5, y=7, colour=3'b101, plot=1 → gnt=4'b0010 after k. The next edge gives vga_x=5, vga_y=7, vga_colour=5, vga_plot=1, owner=1.
- req=4'b0101 simultaneously from reset → requester 0 granted. When req[0] drops: one HANDOFF cycle with gnt=0 and vga_plot=0, then gnt=4'b0100. Requester 0 re-requests during that burst → granted after requester 2 releases.
- Owner plots (160,0), then (0,120), then (159,119) → vga_plot values 0, 0, 1; clip_cnt=2.
- Non-owner 3 asserts req_plot with x=1 while 0 owns the port → vga_x and vga_plot track requester 0 only.
- rst_n pulsed low mid-GRANT → gnt, vga_plot and busy go 0 without waiting for clk. After release, the first request is granted in 1 cycle.

Source files
------------

// File: rtl/vga_plot_arbiter_if.sv
// Bundle between the drawing engines and the vga_adapter pixel port.
//   master: engine side. Drives req/req_x/req_y/req_colour/req_plot and
//           observes gnt and the muxed adapter signals.
//   slave : arbiter side. Samples the engine signals and drives gnt and
//           vga_x/vga_y/vga_colour/vga_plot.
// Engine i owns slice [8i+7:8i] of req_x, [7i+6:7i] of req_y and
// [3i+2:3i] of req_colour.
interface vga_plot_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ*8-1:0] req_x;
    logic [NUM_REQ*7-1:0] req_y;
    logic [NUM_REQ*3-1:0] req_colour;
    logic [NUM_REQ-1:0]   req_plot;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;

    modport master (
        output req, req_x, req_y, req_colour, req_plot,
        input  gnt, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, req_x, req_y, req_colour, req_plot,
        output gnt, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the single vga_adapter pixel port between
// up to NUM_REQ drawing engines. A granted engine keeps the port until it
// drops req; every hand-over passes through one cycle with no grant.
// The owner's pixel is registered (1-cycle latency), off-screen plots are
// suppressed and counted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : engine requests/pixels in, grant and adapter signals out
//   owner      : index of the current or last grantee
//   busy       : high while a grant is held
//   clip_cnt   : saturating count of clipped owner plots
module vga_plot_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_plot_arbiter_if.slave   bus,
    output logic [IDW-1:0]      owner,
    output logic                busy,
    output logic [15:0]         clip_cnt
);

    typedef enum logic [1:0] {StIdle, StGrant, StHandoff} state_e;

    state_e               state_q;
    logic [IDW-1:0]       last_owner_q;
    logic [IDW-1:0]       owner_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 busy_q;
    logic [7:0]           vga_x_q;
    logic [6:0]           vga_y_q;
    logic [2:0]           vga_colour_q;
    logic                 vga_plot_q;
    logic [15:0]          clip_cnt_q;

    logic                 any_req;
    logic [IDW-1:0]       pick;
    logic [7:0]           own_x;
    logic [6:0]           own_y;
    logic [2:0]           own_colour;
    logic                 own_plot;
    logic                 on_screen;

    // Round-robin search starting just after last_owner. Scanning from the
    // farthest candidate down lets the nearest requester win without a break.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int unsigned idx;
            idx = (32'(last_owner_q) + 32'(k)) % NUM_REQ;
            if (bus.req[IDW'(idx)]) begin
                pick    = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        own_x      = bus.req_x[32'(owner_q) * 8 +: 8];
        own_y      = bus.req_y[32'(owner_q) * 7 +: 7];
        own_colour = bus.req_colour[32'(owner_q) * 3 +: 3];
        own_plot   = bus.req_plot[owner_q];
        on_screen  = (32'(own_x) < SCREEN_W) && (32'(own_y) < SCREEN_H);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_owner_q <= IDW'(NUM_REQ - 1);
            owner_q      <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            clip_cnt_q   <= '0;
        end else begin
            vga_plot_q <= 1'b0;
            unique case (state_q)
                StIdle, StHandoff: begin
                    if (any_req) begin
                        state_q      <= StGrant;
                        gnt_q        <= NUM_REQ'(1) << pick;
                        owner_q      <= pick;
                        last_owner_q <= pick;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                StGrant: begin
                    if (!bus.req[owner_q]) begin
                        // Release: the owner's plot this cycle is dropped.
                        state_q <= StHandoff;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        vga_x_q      <= own_x;
                        vga_y_q      <= own_y;
                        vga_colour_q <= own_colour;
                        vga_plot_q   <= own_plot && on_screen;
                        if (own_plot && !on_screen && clip_cnt_q != 16'hFFFF) begin
                            clip_cnt_q <= clip_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign owner          = owner_q;
    assign busy           = busy_q;
    assign clip_cnt       = clip_cnt_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios followed by randomized
// bursts, all compared every cycle against a transaction-level model.
module tb_vga_plot_arbiter;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] owner;
    logic       busy;
    logic [15:0] clip_cnt;

    vga_plot_arbiter_if #(.NUM_REQ(N)) bus ();

    vga_plot_arbiter #(
        .NUM_REQ (N),
        .SCREEN_W(160),
        .SCREEN_H(120)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .owner   (owner),
        .busy    (busy),
        .clip_cnt(clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Model: who holds the port (-1 = nobody), round-robin pointer and
    // the values the adapter should currently see.
    int m_holder;
    int m_last;
    int m_owner;
    int m_x, m_y, m_c;
    int m_plot;
    int m_cnt;
    int m_pix_updated;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_last   = N - 1;
        m_owner  = 0;
        m_x = 0; m_y = 0; m_c = 0;
        m_plot = 0;
        m_cnt  = 0;
        m_pix_updated = 0;
    endtask

    // One clock edge worth of arbitration rules, using the inputs as sampled.
    task automatic model_step();
        int x, y;
        m_plot = 0;
        m_pix_updated = 0;
        if (m_holder >= 0) begin
            if (!bus.req[m_holder]) begin
                m_holder = -1;
            end else begin
                x = int'(bus.req_x[m_holder*8 +: 8]);
                y = int'(bus.req_y[m_holder*7 +: 7]);
                m_x = x;
                m_y = y;
                m_c = int'(bus.req_colour[m_holder*3 +: 3]);
                m_pix_updated = 1;
                if (bus.req_plot[m_holder]) begin
                    if (x < 160 && y < 120) m_plot = 1;
                    else if (m_cnt < 65535) m_cnt++;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (bus.req[i]) begin
                    m_holder = i;
                    m_last   = i;
                    m_owner  = i;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] eg;
        eg = (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0;
        check_eq("gnt", 32'(bus.gnt), eg);
        check_eq("busy", 32'(busy), (m_holder >= 0) ? 32'd1 : 32'd0);
        check_eq("owner", 32'(owner), 32'(m_owner));
        check_eq("vga_plot", 32'(bus.vga_plot), 32'(m_plot));
        check_eq("clip_cnt", 32'(clip_cnt), 32'(m_cnt));
        if (m_pix_updated != 0) begin
            check_eq("vga_x", 32'(bus.vga_x), 32'(m_x));
            check_eq("vga_y", 32'(bus.vga_y), 32'(m_y));
            check_eq("vga_colour", 32'(bus.vga_colour), 32'(m_c));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        else model_reset();
        compare_all();
    endtask

    task automatic set_eng(input int i, input logic r, input int x, input int y,
                           input int c, input logic p);
        bus.req[i]               = r;
        bus.req_x[i*8 +: 8]      = 8'(x);
        bus.req_y[i*7 +: 7]      = 7'(y);
        bus.req_colour[i*3 +: 3] = 3'(c);
        bus.req_plot[i]          = p;
    endtask

    task automatic clear_inputs();
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        bus.req_plot   = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();

        // Reset then idle.
        apply_reset();
        repeat (10) cycle();
        check_eq("idle_gnt", 32'(bus.gnt), 32'd0);
        check_eq("idle_clip", 32'(clip_cnt), 32'd0);

        // Single requester 1: grant after one edge, pixel one edge later.
        set_eng(1, 1'b1, 5, 7, 5, 1'b1);
        cycle();
        check_eq("r1_gnt", 32'(bus.gnt), 32'b0010);
        cycle();
        check_eq("r1_x", 32'(bus.vga_x), 32'd5);
        check_eq("r1_y", 32'(bus.vga_y), 32'd7);
        check_eq("r1_col", 32'(bus.vga_colour), 32'd5);
        check_eq("r1_plot", 32'(bus.vga_plot), 32'd1);
        check_eq("r1_owner", 32'(owner), 32'd1);

        // Simultaneous 0 and 2 from reset; hand-over and re-request.
        apply_reset();
        set_eng(0, 1'b1, 10, 10, 1, 1'b1);
        set_eng(2, 1'b1, 20, 20, 2, 1'b1);
        cycle();
        check_eq("sim_gnt0", 32'(bus.gnt), 32'b0001);
        repeat (3) cycle();
        bus.req[0] = 1'b0;
        cycle();
        check_eq("handoff_gnt", 32'(bus.gnt), 32'd0);
        check_eq("handoff_plot", 32'(bus.vga_plot), 32'd0);
        bus.req[0] = 1'b1;
        cycle();
        check_eq("sim_gnt2", 32'(bus.gnt), 32'b0100);
        repeat (3) cycle();
        bus.req[2] = 1'b0;
        cycle();
        cycle();
        check_eq("regrant0", 32'(bus.gnt), 32'b0001);

        // Clipping: (160,0), (0,120), (159,119).
        apply_reset();
        set_eng(0, 1'b1, 0, 0, 0, 1'b0);
        cycle();
        set_eng(0, 1'b1, 160, 0, 3, 1'b1);
        cycle();
        check_eq("clip_x_plot", 32'(bus.vga_plot), 32'd0);
        set_eng(0, 1'b1, 0, 120, 3, 1'b1);
        cycle();
        check_eq("clip_y_plot", 32'(bus.vga_plot), 32'd0);
        set_eng(0, 1'b1, 159, 119, 3, 1'b1);
        cycle();
        check_eq("corner_plot", 32'(bus.vga_plot), 32'd1);
        check_eq("clip_cnt2", 32'(clip_cnt), 32'd2);

        // Non-owner 3 plotting while 0 owns the port.
        set_eng(0, 1'b1, 10, 11, 6, 1'b0);
        set_eng(3, 1'b1, 1, 1, 7, 1'b1);
        cycle();
        check_eq("nonown_x", 32'(bus.vga_x), 32'd10);
        check_eq("nonown_plot", 32'(bus.vga_plot), 32'd0);
        check_eq("nonown_gnt", 32'(bus.gnt), 32'b0001);

        // Asynchronous reset mid-grant.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("arst_plot", 32'(bus.vga_plot), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        model_reset();
        clear_inputs();
        set_eng(1, 1'b1, 3, 4, 2, 1'b1);
        #2;
        rst_n = 1'b1;
        cycle();
        check_eq("post_rst_gnt", 32'(bus.gnt), 32'b0010);

        // Randomized bursts.
        apply_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                logic r;
                r = bus.req[i];
                if (r) r = ($urandom_range(0, 7) != 0);
                else r = ($urandom_range(0, 5) == 0);
                set_eng(i, r, int'($urandom_range(0, 200)), int'($urandom_range(0, 127)),
                        int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
